// File: rtl/mod_updown_counter.sv
// Modulo-MOD_VALUE up/down counter with load, wrap/saturate mode, wrap pulse and sticky overflow.
// Optional prescaler enabled by defining COUNTER_PRESCALE_EN.
module mod_updown_counter #(
    parameter int unsigned WIDTH     = 4,
    parameter int unsigned MOD_VALUE = 10,
    parameter int unsigned SATURATE  = 0,
    parameter int unsigned PRESCALE  = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             en,
    input  logic             up,
    input  logic             load,
    input  logic [WIDTH-1:0] load_val,
    input  logic             clr_ovf,
    output logic [WIDTH-1:0] count,
    output logic             at_max,
    output logic             at_min,
    output logic             wrap,
    output logic             ovf_sticky
);

    localparam logic [WIDTH:0] MaxVal = (WIDTH + 1)'(MOD_VALUE - 1);
    localparam bit             Sat    = (SATURATE != 0);

    if (MOD_VALUE < 2 || MOD_VALUE > (1 << WIDTH) || PRESCALE < 1) begin : gen_param_check
        $error("mod_updown_counter: illegal MOD_VALUE/WIDTH/PRESCALE combination");
    end

    logic [WIDTH-1:0] count_q, count_d;
    logic             wrap_q, wrap_d;
    logic             ovf_q, ovf_d;
    logic             step;

`ifdef COUNTER_PRESCALE_EN
    localparam int unsigned    PsW    = (PRESCALE > 1) ? $clog2(PRESCALE) : 1;
    localparam logic [PsW-1:0] PsLast = PsW'(PRESCALE - 1);

    logic [PsW-1:0] ps_q, ps_d;

    always_comb begin
        ps_d = ps_q;
        step = 1'b0;
        if (load) begin
            ps_d = '0;
        end else if (en) begin
            if (ps_q == PsLast) begin
                ps_d = '0;
                step = 1'b1;
            end else begin
                ps_d = ps_q + 1'b1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            ps_q <= '0;
        end else begin
            ps_q <= ps_d;
        end
    end
`else
    always_comb begin
        step = en & ~load;
    end
`endif

    logic [WIDTH:0] cnt_ext;
    logic [WIDTH:0] load_ext;
    logic [WIDTH:0] next_ext;
    logic           event_hit;

    always_comb begin
        cnt_ext   = {1'b0, count_q};
        load_ext  = {1'b0, load_val};
        next_ext  = cnt_ext;
        event_hit = 1'b0;

        if (load) begin
            next_ext = (load_ext > MaxVal) ? MaxVal : load_ext;
        end else if (step) begin
            if (up) begin
                if (cnt_ext == MaxVal) begin
                    event_hit = 1'b1;
                    next_ext  = Sat ? cnt_ext : '0;
                end else begin
                    next_ext = cnt_ext + 1'b1;
                end
            end else begin
                if (cnt_ext == '0) begin
                    event_hit = 1'b1;
                    next_ext  = Sat ? cnt_ext : MaxVal;
                end else begin
                    next_ext = cnt_ext - 1'b1;
                end
            end
        end

        count_d = next_ext[WIDTH-1:0];
        wrap_d  = event_hit & ~Sat;
        // A new overflow on the same edge as clr_ovf keeps the flag set.
        ovf_d   = event_hit | (ovf_q & ~clr_ovf);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            count_q <= '0;
            wrap_q  <= 1'b0;
            ovf_q   <= 1'b0;
        end else begin
            count_q <= count_d;
            wrap_q  <= wrap_d;
            ovf_q   <= ovf_d;
        end
    end

    always_comb begin
        count      = count_q;
        wrap       = wrap_q;
        ovf_sticky = ovf_q;
        at_max     = ({1'b0, count_q} == MaxVal);
        at_min     = (count_q == '0);
    end

endmodule

// File: tb/tb_mod_updown_counter.sv
// Randomized bench for mod_updown_counter: three instances against a behavioural model,
// plus directed literal checks on the documented scenarios.
module tb_mod_updown_counter;

    logic       clk = 1'b0;
    logic       rst, en, up, load, clr_ovf;
    logic [3:0] load_val;
    logic [3:0] c0, c2;
    logic [2:0] c1;
    logic [2:0] mx, mn, wr, ov;

    always #5 clk = ~clk;

    mod_updown_counter #(.WIDTH(4), .MOD_VALUE(10), .SATURATE(0), .PRESCALE(4)) dut0 (
        .clk(clk), .rst(rst), .en(en), .up(up), .load(load), .load_val(load_val),
        .clr_ovf(clr_ovf), .count(c0), .at_max(mx[0]), .at_min(mn[0]), .wrap(wr[0]),
        .ovf_sticky(ov[0])
    );

    mod_updown_counter #(.WIDTH(3), .MOD_VALUE(8), .SATURATE(0), .PRESCALE(4)) dut1 (
        .clk(clk), .rst(rst), .en(en), .up(up), .load(load), .load_val(load_val[2:0]),
        .clr_ovf(clr_ovf), .count(c1), .at_max(mx[1]), .at_min(mn[1]), .wrap(wr[1]),
        .ovf_sticky(ov[1])
    );

    mod_updown_counter #(.WIDTH(4), .MOD_VALUE(10), .SATURATE(1), .PRESCALE(4)) dut2 (
        .clk(clk), .rst(rst), .en(en), .up(up), .load(load), .load_val(load_val),
        .clr_ovf(clr_ovf), .count(c2), .at_max(mx[2]), .at_min(mn[2]), .wrap(wr[2]),
        .ovf_sticky(ov[2])
    );

`ifdef COUNTER_PRESCALE_EN
    localparam int PsLim = 4;
`else
    localparam int PsLim = 1;
`endif

    typedef struct {
        int cnt;
        int wrp;
        int ovf;
        int ps;
    } st_t;

    st_t m[3];
    int  mods[3] = '{10, 8, 10};
    int  sats[3] = '{0, 0, 1};
    int  n_cmp = 0;
    int  n_bad = 0;
    bit  chk_on = 1'b0;

    task automatic chk(input string name, input int act, input int exp);
        n_cmp++;
        if (act != exp) begin
            n_bad++;
            $display("FAIL %s at %0t: got %0d, expected %0d", name, $time, act, exp);
        end
    endtask

    // Spec-level model: the count is an integer in 0..md-1, a step leaving that range is an event.
    function automatic st_t nxt(input st_t s, input int md, input int sat, input int lv);
        st_t r;
        int  t;
        r     = s;
        r.wrp = 0;
        r.ovf = (s.ovf != 0 && !clr_ovf) ? 1 : 0;
        if (rst) begin
            r = '{0, 0, 0, 0};
        end else if (load) begin
            r.cnt = (lv > md - 1) ? md - 1 : lv;
            r.ps  = 0;
        end else if (en) begin
            r.ps = s.ps + 1;
            if (r.ps == PsLim) begin
                r.ps = 0;
                t = up ? s.cnt + 1 : s.cnt - 1;
                if (t < 0 || t >= md) begin
                    r.ovf = 1;
                    if (sat == 0) begin
                        r.cnt = (t + md) % md;
                        r.wrp = 1;
                    end
                end else begin
                    r.cnt = t;
                end
            end
        end
        return r;
    endfunction

    always @(posedge clk) begin
        m[0] <= nxt(m[0], mods[0], sats[0], int'(load_val));
        m[1] <= nxt(m[1], mods[1], sats[1], int'(load_val[2:0]));
        m[2] <= nxt(m[2], mods[2], sats[2], int'(load_val));
    end

    always @(negedge clk) begin
        if (chk_on) begin
            for (int i = 0; i < 3; i++) begin
                int act;
                act = (i == 0) ? int'(c0) : (i == 1) ? int'(c1) : int'(c2);
                chk($sformatf("model_count%0d", i), act, m[i].cnt);
                chk($sformatf("model_wrap%0d", i), int'(wr[i]), m[i].wrp);
                chk($sformatf("model_ovf%0d", i), int'(ov[i]), m[i].ovf);
                chk($sformatf("model_max%0d", i), int'(mx[i]), (m[i].cnt == mods[i] - 1) ? 1 : 0);
                chk($sformatf("model_min%0d", i), int'(mn[i]), (m[i].cnt == 0) ? 1 : 0);
            end
        end
    end

    task automatic step();
        @(negedge clk);
    endtask

    initial begin
        rst = 1'b1; en = 1'b0; up = 1'b1; load = 1'b0; load_val = 4'd0; clr_ovf = 1'b0;
        step();
        chk_on = 1'b1;
        chk("rst_count", int'(c0), 0);
        chk("rst_min", int'(mn[0]), 1);
        chk("rst_max", int'(mx[0]), 0);
        chk("rst_wrap", int'(wr[0]), 0);
        chk("rst_ovf", int'(ov[0]), 0);
        rst = 1'b0; en = 1'b1; up = 1'b1;
`ifndef COUNTER_PRESCALE_EN
        for (int k = 1; k <= 12; k++) begin
            step();
            chk("up_count", int'(c0), k % 10);
            chk("up_wrap", int'(wr[0]), (k == 10) ? 1 : 0);
            chk("up_max", int'(mx[0]), (k == 9) ? 1 : 0);
            chk("up_ovf", int'(ov[0]), (k >= 10) ? 1 : 0);
        end
        load = 1'b1; load_val = 4'd0;
        step();
        chk("load0_count", int'(c0), 0);
        load = 1'b0; up = 1'b0;
        step();
        chk("dn_wrap_count", int'(c0), 9);
        chk("dn_wrap_pulse", int'(wr[0]), 1);
        step();
        chk("dn_count", int'(c0), 8);
        chk("dn_wrap_off", int'(wr[0]), 0);
        en = 1'b0; clr_ovf = 1'b1;
        step();
        chk("clr_ovf", int'(ov[0]), 0);
        clr_ovf = 1'b0; load = 1'b1; load_val = 4'd0; en = 1'b1;
        step();
        chk("load_no_ovf", int'(ov[0]), 0);
        load = 1'b0; up = 1'b0; clr_ovf = 1'b1;
        step();
        chk("set_wins_count", int'(c0), 9);
        chk("set_wins_ovf", int'(ov[0]), 1);
        clr_ovf = 1'b0; load = 1'b1; load_val = 4'd13;
        step();
        chk("clamp_count", int'(c0), 9);
        chk("clamp_wrap", int'(wr[0]), 0);
        chk("clamp_ovf", int'(ov[0]), 1);
        load_val = 4'd5;
        step();
        chk("load5", int'(c0), 5);
        load = 1'b0; up = 1'b1;
        step();
        chk("pre_rst", int'(c0), 6);
        rst = 1'b1;
        step();
        chk("mid_rst_count", int'(c0), 0);
        chk("mid_rst_wrap", int'(wr[0]), 0);
        chk("mid_rst_ovf", int'(ov[0]), 0);
        rst = 1'b0;
        step();
        chk("resume1", int'(c0), 1);
        step();
        chk("resume2", int'(c0), 2);
        load = 1'b1; load_val = 4'd7;
        step();
        chk("sat_load", int'(c2), 7);
        load = 1'b0; up = 1'b1;
        for (int k = 1; k <= 5; k++) begin
            step();
            chk("sat_up_count", int'(c2), (k == 1) ? 8 : 9);
            chk("sat_up_wrap", int'(wr[2]), 0);
            chk("sat_up_ovf", int'(ov[2]), (k >= 3) ? 1 : 0);
        end
        load = 1'b1; load_val = 4'd1;
        step();
        load = 1'b0; up = 1'b0;
        step();
        chk("sat_dn0", int'(c2), 0);
        step();
        chk("sat_dn_hold", int'(c2), 0);
        chk("sat_dn_wrap", int'(wr[2]), 0);
`else
        for (int k = 1; k <= 12; k++) begin
            step();
            chk("ps_count", int'(c0), k / 4);
        end
        step();
        step();
        en = 1'b0;
        for (int k = 0; k < 3; k++) begin
            step();
            chk("ps_hold", int'(c0), 3);
        end
        en = 1'b1;
        step();
        chk("ps_phase_kept", int'(c0), 3);
        step();
        chk("ps_phase_step", int'(c0), 4);
        step();
        load = 1'b1; load_val = 4'd0;
        step();
        load = 1'b0;
        for (int k = 1; k <= 4; k++) begin
            step();
            chk("ps_after_load", int'(c0), (k == 4) ? 1 : 0);
        end
`endif
        for (int n = 0; n < 3000; n++) begin
            rst      = ($urandom_range(0, 199) == 0);
            load     = ($urandom_range(0, 99) < 8);
            en       = ($urandom_range(0, 99) < 75);
            up       = ($urandom_range(0, 99) < ((n / 300) % 2 == 0 ? 80 : 20));
            clr_ovf  = ($urandom_range(0, 99) < 6);
            load_val = 4'($urandom_range(0, 15));
            step();
        end
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

// File: doc/mod_updown_counter.md
Name: mod_updown_counter

Overview:
Parametrised successor to the team's free-running 4-bit counter. Counts modulo MOD_VALUE, either up or down, with synchronous parallel load, count enable, and wrap or saturate selectable per instance. Provides terminal flags, a registered wrap pulse and a sticky overflow flag. Used as a generic event/BCD/timer counter in datapath and test structures.

Parameters:
WIDTH, 4, width of count and load_val; MOD_VALUE must be <= 2**WIDTH
MOD_VALUE, 10, modulus; legal count range 0..MOD_VALUE-1; must be >= 2
SATURATE, 0, 0 = wrap at terminal value, 1 = hold at terminal value
PRESCALE, 4, enabled cycles per count step; used only when COUNTER_PRESCALE_EN is defined; must be >= 1

Ports:
clk  input  1  single clock, all state updates on rising edge
rst  input  1  synchronous, active-high reset
en  input  1  count enable; one step per enabled cycle (see prescaler)
up  input  1  direction: 1 = increment, 0 = decrement; sampled with en
load  input  1  synchronous parallel load
load_val  input  WIDTH  value for load
clr_ovf  input  1  clears ovf_sticky
count  output  WIDTH  current count, registered
at_max  output  1  combinational: count == MOD_VALUE-1
at_min  output  1  combinational: count == 0
wrap  output  1  registered one-cycle pulse, asserted the cycle after a wrap
ovf_sticky  output  1  registered sticky flag: a wrap or saturation-blocked step occurred

Behaviour:
- Interface: one clock clk; rst is synchronous and active-high.
- Reset (rst=1 at rising edge): count=0, wrap=0, ovf_sticky=0, prescaler=0. at_min=1 and at_max=0 follow from count. rst overrides all other inputs.
- Priority per edge: rst > load > en. en is ignored when load=1.
- load: count <= load_val if load_val <= MOD_VALUE-1, else MOD_VALUE-1 (clamp). A load never asserts wrap and never sets ovf_sticky.
- Step, en=1, up=1: if count < MOD_VALUE-1 then count+1. At MOD_VALUE-1: with SATURATE=0 go to 0, assert wrap next cycle and set ovf_sticky; with SATURATE=1 hold and set ovf_sticky, wrap stays 0.
- Step, en=1, up=0: if count > 0 then count-1. At 0: with SATURATE=0 go to MOD_VALUE-1, assert wrap and set ovf_sticky; with SATURATE=1 hold and set ovf_sticky.
- en=0: count holds and wrap=0.
- wrap is high for exactly one cycle per wrap event. Back-to-back wraps (MOD_VALUE=2, continuous en) keep wrap high on consecutive cycles.
- ovf_sticky stays set until clr_ovf or rst. If clr_ovf and a new overflow event fall on the same edge, set wins and ovf_sticky stays 1.
- Arithmetic is done at WIDTH+1 bits internally. count never leaves 0..MOD_VALUE-1, including when MOD_VALUE == 2**WIDTH.
- Direction change takes effect on the same edge it is sampled; there is no pipeline.
- Latency: count updates 1 cycle after an enabled input; at_max and at_min are valid in the same cycle as count.

Optional Feature:
COUNTER_PRESCALE_EN
- Defined: an internal prescaler (width clog2(PRESCALE), minimum 1 bit) increments on each cycle with en=1 and load=0. The count step and all wrap/overflow evaluation happen only on the enabled cycle where the prescaler equals PRESCALE-1; the prescaler then returns to 0. rst and load clear the prescaler. en=0 freezes it. PRESCALE=1 behaves identically to the undefined case.
- Undefined: no prescaler logic; every enabled cycle is a step and PRESCALE is ignored.

Test Plan:
- Reset then count up: rst=1 for 1 cycle, then en=1, up=1 for 12 cycles (defaults) -> count 0,1,...,9,0,1. wrap high exactly one cycle after 9->0; ovf_sticky=1 from then on; at_max=1 only while count=9.
- Down wrap and clear: load load_val=0, then en=1, up=0 -> count 9, 8. wrap pulses once. clr_ovf=1 for 1 cycle -> ovf_sticky=0. clr_ovf raised on the same edge as the next wrap -> ovf_sticky stays 1.
- Saturate mode (SATURATE=1): up from 7 for 5 cycles -> 8, 9, 9, 9, 9. wrap never asserts; ovf_sticky=1 after the first blocked step. Down from 1 -> 0, 0.
- Load priority and clamp: load=1, en=1, load_val=13 -> count=9 with no wrap and no ovf change. load_val=5 -> count=5.
- Mid-operation reset: en=1 counting at count=6, rst=1 for 1 cycle -> count=0, wrap=0, ovf_sticky=0 the next cycle. Counting resumes 1, 2 once rst=0.
- Prescaler (COUNTER_PRESCALE_EN, PRESCALE=4): en=1, up=1 for 12 cycles -> count steps at cycles 4, 8, 12 to 1, 2, 3. en dropped for 3 cycles mid-period -> phase is held. A load mid-period restarts a full 4-cycle period.
